// File: rtl/key_entry_dec.sv
// Keypad digit entry buffer: debounced-press FSM, 4-digit BCD shift buffer, one-hot decode.
// Define KEY_ENTRY_SCAN_EN to add the multiplexed 7-segment scan outputs (seg, an).
module key_entry_dec #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  d_in,
    input  logic        loadn,
    input  logic        clear,
    output logic [9:0]  dec_out,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic        valid,
    output logic        err
`ifdef KEY_ENTRY_SCAN_EN
    ,
    output logic [6:0]  seg,
    output logic [3:0]  an
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state;
    logic       press;
    logic       accept;

    // Exactly one event per press: only the IDLE->HOLD transition counts.
    assign press  = (state == IDLE) && !loadn;
    assign accept = (d_in <= 4'd9) && (count < 3'd4);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= loadn ? IDLE : HOLD;
        end
    end

    // Clear overrides a coincident press but leaves the FSM alone, so a held key stays consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            digits  <= 16'h0000;
            count   <= 3'd0;
            dec_out <= 10'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (clear) begin
                digits  <= 16'h0000;
                count   <= 3'd0;
                dec_out <= 10'b0;
            end else if (press) begin
                if (accept) begin
                    digits  <= {digits[11:0], d_in};
                    count   <= count + 3'd1;
                    dec_out <= 10'b1 << d_in;
                    valid   <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef KEY_ENTRY_SCAN_EN
    logic [15:0] pre_cnt;
    logic [1:0]  slot;
    logic [3:0]  nib;
    logic [6:0]  seg_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= 16'd0;
            slot    <= 2'd0;
        end else if (pre_cnt == SCAN_DIV - 16'd1) begin
            pre_cnt <= 16'd0;
            slot    <= slot + 2'd1;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    assign nib = digits[{slot, 2'b00} +: 4];

    // Active-low, bit 0 = segment a ... bit 6 = segment g.
    always_comb begin
        seg_nxt = 7'b1111111;
        case (nib)
            4'd0: seg_nxt = 7'b1000000;
            4'd1: seg_nxt = 7'b1111001;
            4'd2: seg_nxt = 7'b0100100;
            4'd3: seg_nxt = 7'b0110000;
            4'd4: seg_nxt = 7'b0011001;
            4'd5: seg_nxt = 7'b0010010;
            4'd6: seg_nxt = 7'b0000010;
            4'd7: seg_nxt = 7'b1111000;
            4'd8: seg_nxt = 7'b0000000;
            4'd9: seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b1111111;
        endcase
    end

    // Slots beyond the number of held digits stay dark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if ({1'b0, slot} < count) begin
            an  <= ~(4'b0001 << slot);
            seg <= seg_nxt;
        end else begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end
    end
`endif

endmodule

// File: tb/tb_key_entry_dec.sv
// Directed bench for key_entry_dec; scan checks run when KEY_ENTRY_SCAN_EN is defined.
module tb_key_entry_dec;

    logic        clk;
    logic        resetn;
    logic [3:0]  d_in;
    logic        loadn;
    logic        clear;
    logic [9:0]  dec_out;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        valid;
    logic        err;
`ifdef KEY_ENTRY_SCAN_EN
    logic [6:0]  seg;
    logic [3:0]  an;
`endif

    int vectors;
    int miscompares;

    key_entry_dec #(.SCAN_DIV(16'd4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .d_in    (d_in),
        .loadn   (loadn),
        .clear   (clear),
        .dec_out (dec_out),
        .digits  (digits),
        .count   (count),
        .valid   (valid),
        .err     (err)
`ifdef KEY_ENTRY_SCAN_EN
        ,
        .seg     (seg),
        .an      (an)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full press/release; leaves the DUT one cycle after release.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        d_in  = d;
        loadn = 1'b0;
        step();
        @(negedge clk);
        loadn = 1'b1;
        step();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        step();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        loadn  = 1'b1;
        clear  = 1'b0;
        d_in   = 4'd0;
        #12;
        vectors++;
        if ({digits, count, dec_out, valid, err} !== {16'h0000, 3'd0, 10'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: digits=%h count=%0d dec=%b valid=%b err=%b", digits, count, dec_out, valid, err);
        end
`ifdef KEY_ENTRY_SCAN_EN
        vectors++;
        if ({an, seg} !== {4'b1111, 7'b1111111}) begin
            miscompares++;
            $display("FAIL reset_scan: an=%b seg=%b want 1111/1111111", an, seg);
        end
`endif
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_press();
        @(negedge clk);
        d_in  = 4'd5;
        loadn = 1'b0;
        step();
        vectors++;
        if ({valid, err, digits, count, dec_out} !== {1'b1, 1'b0, 16'h0005, 3'd1, 10'b0000100000}) begin
            miscompares++;
            $display("FAIL single_capture: v=%b e=%b digits=%h count=%0d dec=%b", valid, err, digits, count, dec_out);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({valid, count} !== {1'b0, 3'd1}) begin
                miscompares++;
                $display("FAIL single_hold%0d: valid=%b count=%0d want 0/1", i, valid, count);
            end
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
        vectors++;
        if ({valid, digits, count} !== {1'b0, 16'h0005, 3'd1}) begin
            miscompares++;
            $display("FAIL single_release: valid=%b digits=%h count=%0d", valid, digits, count);
        end
    endtask

    task automatic test_full();
        do_clear();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        @(negedge clk);
        d_in  = 4'd4;
        loadn = 1'b0;
        step();
        vectors++;
        if ({valid, digits, count, dec_out} !== {1'b1, 16'h1234, 3'd4, 10'b0000010000}) begin
            miscompares++;
            $display("FAIL fill4: valid=%b digits=%h count=%0d dec=%b", valid, digits, count, dec_out);
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
        @(negedge clk);
        d_in  = 4'd7;
        loadn = 1'b0;
        step();
        vectors++;
        if ({err, valid, digits, count, dec_out} !== {1'b1, 1'b0, 16'h1234, 3'd4, 10'b0000010000}) begin
            miscompares++;
            $display("FAIL full_reject: err=%b valid=%b digits=%h count=%0d dec=%b", err, valid, digits, count, dec_out);
        end
        step();
        vectors++;
        if ({err, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL full_err_pulse: err=%b valid=%b want 0/0", err, valid);
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
    endtask

    task automatic test_invalid_digit();
        do_clear();
        @(negedge clk);
        d_in  = 4'hC;
        loadn = 1'b0;
        step();
        vectors++;
        if ({err, valid, digits, count, dec_out} !== {1'b1, 1'b0, 16'h0000, 3'd0, 10'b0}) begin
            miscompares++;
            $display("FAIL invalid_C: err=%b valid=%b digits=%h count=%0d dec=%b", err, valid, digits, count, dec_out);
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
        @(negedge clk);
        d_in  = 4'd9;
        loadn = 1'b0;
        step();
        vectors++;
        if ({valid, err, digits, count, dec_out} !== {1'b1, 1'b0, 16'h0009, 3'd1, 10'b1000000000}) begin
            miscompares++;
            $display("FAIL digit9: valid=%b err=%b digits=%h count=%0d dec=%b", valid, err, digits, count, dec_out);
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
    endtask

    task automatic test_clear();
        press(4'd3);
        @(negedge clk);
        d_in  = 4'd6;
        loadn = 1'b0;
        clear = 1'b1;
        step();
        vectors++;
        if ({valid, err, digits, count, dec_out} !== {1'b0, 1'b0, 16'h0000, 3'd0, 10'b0}) begin
            miscompares++;
            $display("FAIL clear_wins: valid=%b err=%b digits=%h count=%0d dec=%b", valid, err, digits, count, dec_out);
        end
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({valid, err, count} !== {1'b0, 1'b0, 3'd0}) begin
                miscompares++;
                $display("FAIL clear_held%0d: valid=%b err=%b count=%0d want 0/0/0", i, valid, err, count);
            end
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        do_clear();
        press(4'd1);
        @(negedge clk);
        d_in  = 4'd2;
        loadn = 1'b0;
        step();
        step();
        vectors++;
        if ({digits, count} !== {16'h0012, 3'd2}) begin
            miscompares++;
            $display("FAIL pre_reset: digits=%h count=%0d want 0012/2", digits, count);
        end
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({digits, count, dec_out, valid, err} !== {16'h0000, 3'd0, 10'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: digits=%h count=%0d dec=%b valid=%b err=%b", digits, count, dec_out, valid, err);
        end
        @(negedge clk);
        resetn = 1'b1;
        step();
        vectors++;
        if ({valid, digits, count, dec_out} !== {1'b1, 16'h0002, 3'd1, 10'b0000000100}) begin
            miscompares++;
            $display("FAIL reset_release_capture: valid=%b digits=%h count=%0d dec=%b", valid, digits, count, dec_out);
        end
        step();
        vectors++;
        if ({valid, count} !== {1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL reset_release_once: valid=%b count=%0d want 0/1", valid, count);
        end
        @(negedge clk);
        loadn = 1'b1;
        step();
    endtask

`ifdef KEY_ENTRY_SCAN_EN
    task automatic test_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       found;
        do_clear();
        press(4'd1);
        press(4'd2);
        found = 1'b0;
        // Align to the start of slot 0 (an falling into 1110).
        for (int i = 0; i < 40 && !found; i++) begin
            logic [3:0] prev;
            prev = an;
            step();
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL scan_align: an never entered 1110 within 40 cycles");
        end else begin
            for (int k = 0; k < 16; k++) begin
                exp_an  = (k < 4) ? 4'b1110 : (k < 8) ? 4'b1101 : 4'b1111;
                exp_seg = (k < 4) ? 7'b0100100 : (k < 8) ? 7'b1111001 : 7'b1111111;
                if (k > 0) step();
                vectors++;
                if ({an, seg} !== {exp_an, exp_seg}) begin
                    miscompares++;
                    $display("FAIL scan_k%0d: an=%b seg=%b want %b/%b", k, an, seg, exp_an, exp_seg);
                end
            end
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_press();
        test_full();
        test_invalid_digit();
        test_clear();
        test_async_reset();
`ifdef KEY_ENTRY_SCAN_EN
        test_scan();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // valid and err must never coincide.
    always @(negedge clk) begin
        if (resetn && valid && err) begin
            miscompares++;
            $display("FAIL valid_err_overlap: valid=%b err=%b", valid, err);
        end
    end

endmodule

// File: doc/key_entry_dec.md
KEY_ENTRY_DEC -- requirements
Module: key_entry_dec

Interface
REQ-001 Parameter SCAN_DIV, default 16'd50000, clk cycles per display-digit scan slot (SCAN_EN builds only).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 d_in  input  4  binary digit code from the keypad encoder, synchronous to clk.
REQ-005 loadn  input  1  active-low key strobe from the keypad encoder, synchronous to clk.
REQ-006 clear  input  1  synchronous active-high clear of the entry buffer.
REQ-007 dec_out  output  10  one-hot decode of the last accepted digit (bit k set for digit k); all zeros when the buffer is empty.
REQ-008 digits  output  16  entry buffer, four BCD nibbles; [3:0] holds the most recent digit.
REQ-009 count  output  3  number of digits held, 0..4.
REQ-010 valid  output  1  one-cycle pulse on each accepted digit.
REQ-011 err  output  1  one-cycle pulse on each rejected press.
REQ-012 seg  output  7  active-low segments a..g (SCAN_EN builds only).
REQ-013 an  output  4  active-low digit anodes (SCAN_EN builds only).

Function
REQ-014 Press FSM SHALL have two states: IDLE (key released) and HOLD (key held).
REQ-015 IDLE->HOLD SHALL occur on the rising edge where loadn is sampled 0; exactly one press event is generated per transition.
REQ-016 HOLD->IDLE SHALL occur on the first rising edge where loadn is sampled 1; loadn 0 while in HOLD SHALL generate no event.
REQ-017 A press with d_in <= 9 and count < 4 SHALL be accepted on the transition edge: digits shifts left by one nibble, d_in enters [3:0], count increments, dec_out becomes one-hot of d_in, valid = 1 for the following cycle only.
REQ-018 A press with d_in >= 10 SHALL be rejected with digits, count and dec_out unchanged, err = 1 for one cycle.
REQ-019 A press with count = 4 (buffer full) SHALL be rejected with digits, count and dec_out unchanged, err = 1 for one cycle; the buffer SHALL never wrap.
REQ-020 Capture latency SHALL be zero: outputs reflect the new digit immediately after the sampling edge.
REQ-021 clear = 1 SHALL zero digits, count and dec_out on that edge and suppress valid/err; clear wins over a simultaneous press.
REQ-022 clear SHALL NOT change the FSM state; a key held through clear generates no new event until released and pressed again.
REQ-023 valid and err SHALL never be asserted in the same cycle.

Reset
REQ-024 resetn = 0 SHALL immediately force FSM = IDLE, digits = 16'h0000, count = 0, dec_out = 10'b0, valid = 0, err = 0, with the scan counter, slot index, seg and an all at reset value (an = 4'b1111, seg = 7'b1111111).
REQ-025 Reset asserted mid-press SHALL discard the press; if loadn is still 0 at release of reset, FSM SHALL enter HOLD and capture on the first edge (press counts once).

Configuration
REQ-026 Macro KEY_ENTRY_SCAN_EN: when defined, a prescaler counts to SCAN_DIV-1 and then advances a 2-bit slot index, mod 4.
REQ-027 With KEY_ENTRY_SCAN_EN, an drives slot i low and seg shows digits nibble i, registered.
REQ-028 With KEY_ENTRY_SCAN_EN, slots with index >= count are blanked (an high).
REQ-029 Without KEY_ENTRY_SCAN_EN, seg and an and all scan logic SHALL be absent from the module; all other behaviour is identical.

Verification
REQ-030 Reset; loadn=0 with d_in=5 for 3 cycles, then 1 -> one valid pulse, digits=16'h0005, count=1, dec_out=10'b0000100000.
REQ-031 Accept 1,2,3,4, then press 7 -> digits=16'h1234, count=4, err pulse, no valid.
REQ-032 Press with d_in=4'hC -> err pulse, outputs unchanged; then press d_in=9 -> dec_out=10'b1000000000.
REQ-033 Press and clear=1 on the same edge -> count=0, digits=0, no valid; holding loadn=0 afterwards gives no capture.
REQ-034 Assert resetn=0 while in HOLD with count=2 -> all outputs cleared immediately, asynchronously to clk.
REQ-035 KEY_ENTRY_SCAN_EN, SCAN_DIV=4, digits=16'h0012, count=2 -> an cycles 1110,1101,1111,1111, each for 4 cycles; seg shows 2 then 1.
